// File: rtl/opt3_pe_result_accumulator.sv
`timescale 1ns/1ps
// opt3_pe_result_accumulator
//   Downstream stage of top_pe. Each beat carries two signed lanes from one
//   2-bit EN-T plane pass. The lanes are fused, weighted by plane position
//   (<< 2*bw_count) and accumulated over all planes and K/4 groups of one
//   dot product. The signed inner product is then offered over valid/ready.
//
//   Optional build macro: OPT3_ACC_SAT_EN
//     defined   : on overflow the accumulator clamps to the signed ACC_W limits
//     undefined : the accumulator wraps (two's complement)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a new dot product (clears accumulator)
//   pe_valid            pe_result / bw_count / last qualify this cycle
//   pe_result           {lane1, lane0}, each LANE_W bits signed
//   bw_count            plane index of the beat
//   last                final beat of the dot product
//   in_ready            beats accepted (state != DONE)
//   acc_valid/acc_ready result handshake
//   acc_result          signed inner product
//   busy                not idle, or a beat in flight
//   overflow            sticky signed overflow in current product
//   proto_err           sticky: dropped beat, illegal start or bw_count
module opt3_pe_result_accumulator #(
    parameter int LANE_W    = 26,
    parameter int ACC_W     = 32,
    parameter int BW_PASSES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pe_valid,
    input  logic [2*LANE_W-1:0] pe_result,
    input  logic [2:0]          bw_count,
    input  logic                last,
    output logic                in_ready,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic [ACC_W-1:0]    acc_result,
    output logic                busy,
    output logic                overflow,
    output logic                proto_err
);

    localparam int FUSE_W  = LANE_W + 1;
    localparam int SHIFT_W = LANE_W + 2*BW_PASSES - 1;
    localparam int W_I     = ((ACC_W > SHIFT_W) ? ACC_W : SHIFT_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      ovf_q, ovf_d;
    logic                      perr_q, perr_d;
    logic                      vld_p1_q, vld_p1_d;
    logic signed [FUSE_W-1:0]  fuse_p1_q, fuse_p1_d;
    logic [2:0]                bw_p1_q, bw_p1_d;
    logic                      last_p1_q, last_p1_d;

    logic signed [LANE_W-1:0]  lane0, lane1;
    logic signed [FUSE_W-1:0]  fuse;
    logic signed [W_I-1:0]     acc_ext, fuse_ext, wide;
    logic                      wide_ovf;
    logic                      accept, bw_ok, clear;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [W_I-1:0] w);
        logic signed [ACC_W-1:0] r;
        if (w[W_I-1:ACC_W-1] == {(W_I-ACC_W+1){w[W_I-1]}})
            r = w[ACC_W-1:0];
        else if (w[W_I-1])
            r = {1'b1, {(ACC_W-1){1'b0}}};
        else
            r = {1'b0, {(ACC_W-1){1'b1}}};
        return r;
    endfunction

    assign in_ready   = rst_n && (state_q != DONE);
    assign acc_valid  = (state_q == DONE);
    assign acc_result = acc_q;
    assign busy       = (state_q != IDLE) || vld_p1_q;
    assign overflow   = ovf_q;
    assign proto_err  = perr_q;

    assign lane0    = pe_result[LANE_W-1:0];
    assign lane1    = pe_result[2*LANE_W-1:LANE_W];
    assign fuse     = {lane0[LANE_W-1], lane0} + {lane1[LANE_W-1], lane1};
    assign acc_ext  = {{(W_I-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign fuse_ext = {{(W_I-FUSE_W){fuse_p1_q[FUSE_W-1]}}, fuse_p1_q};
    assign wide     = acc_ext + (fuse_ext <<< {bw_p1_q, 1'b0});
    assign wide_ovf = (wide[W_I-1:ACC_W-1] != {(W_I-ACC_W+1){wide[W_I-1]}});

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        perr_d    = perr_q;
        vld_p1_d  = 1'b0;
        fuse_p1_d = fuse_p1_q;
        bw_p1_d   = bw_p1_q;
        last_p1_d = last_p1_q;
        clear     = 1'b0;
        accept    = pe_valid && in_ready && ((state_q == ACCUM) || start);
        bw_ok     = int'(bw_count) < BW_PASSES;

        // ---- stage S2: weighted beat folded into accumulator ----
        if (vld_p1_q) begin
            if (state_q == ACCUM) begin
`ifdef OPT3_ACC_SAT_EN
                acc_d = sat_acc(wide);
`else
                acc_d = wide[ACC_W-1:0];
`endif
                if (wide_ovf)
                    ovf_d = 1'b1;
                if (last_p1_q)
                    state_d = DONE;
            end else begin
                // beat trailing a last arrives after the result is frozen
                perr_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE:  if (start) clear = 1'b1;
            ACCUM: if (start) clear = 1'b1;
            DONE: begin
                if (acc_ready) begin
                    state_d = IDLE;
                    if (start)
                        clear = 1'b1;
                end else if (start) begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // a restart overrides any fold or DONE transition this cycle
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end

        // ---- stage S1: lane fusion ----
        if (accept) begin
            vld_p1_d  = 1'b1;
            last_p1_d = last;
            if (bw_ok) begin
                fuse_p1_d = fuse;
                bw_p1_d   = bw_count;
            end else begin
                // illegal plane contributes nothing but still carries last
                fuse_p1_d = '0;
                bw_p1_d   = '0;
                perr_d    = 1'b1;
            end
        end else if (pe_valid) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            vld_p1_q  <= 1'b0;
            fuse_p1_q <= '0;
            bw_p1_q   <= '0;
            last_p1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
            vld_p1_q  <= vld_p1_d;
            fuse_p1_q <= fuse_p1_d;
            bw_p1_q   <= bw_p1_d;
            last_p1_q <= last_p1_d;
        end
    end

endmodule

// File: tb/tb_opt3_pe_result_accumulator.sv
`timescale 1ns/1ps
module tb_opt3_pe_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pe_valid;
    logic [51:0] pe_result;
    logic [2:0]  bw_count;
    logic        last;
    logic        in_ready;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_result;
    logic        busy;
    logic        overflow;
    logic        proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: exact arithmetic on 64-bit integers
    longint acc_m;
    bit     ovf_m;
    bit     perr_m;

    always #5 clk = ~clk;

    opt3_pe_result_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pe_valid   (pe_valid),
        .pe_result  (pe_result),
        .bw_count   (bw_count),
        .last       (last),
        .in_ready   (in_ready),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_result (acc_result),
        .busy       (busy),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        acc_m = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_add(input int l0, input int l1, input int bw);
        longint w;
        w = acc_m + (longint'(l0) + longint'(l1)) * (longint'(1) << (2*bw));
        if (w > 64'sd2147483647 || w < -64'sd2147483648) begin
            ovf_m = 1'b1;
`ifdef OPT3_ACC_SAT_EN
            w = (w > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
            w = longint'(int'(w));
`endif
        end
        acc_m = w;
    endtask

    task automatic send(input bit st, input int l0, input int l1, input int bw, input bit lst);
        logic [25:0] a;
        logic [25:0] b;
        a         = l0[25:0];
        b         = l1[25:0];
        start     = st;
        pe_valid  = 1'b1;
        pe_result = {b, a};
        bw_count  = bw[2:0];
        last      = lst;
        tick();
        start    = 1'b0;
        pe_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (acc_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(acc_valid === 1'b1), 64'd1);
    endtask

    task automatic check_result(input string tag);
        logic [31:0] e;
        e = acc_m[31:0];
        chk({tag, "_res"}, 64'(acc_result), 64'(e));
        chk({tag, "_ovf"}, 64'(overflow), 64'(ovf_m));
        chk({tag, "_perr"}, 64'(proto_err), 64'(perr_m));
    endtask

    task automatic handshake(input string tag);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk({tag, "_vld_fall"}, 64'(acc_valid), 64'd0);
    endtask

    task automatic run_random(input int idx);
        int nb;
        int l0;
        int l1;
        int bw;
        bit big;
        nb  = $urandom_range(1, 7);
        big = ($urandom_range(0, 3) == 0);
        model_clear();
        for (int i = 0; i < nb; i++) begin
            if (big) begin
                l0 = int'($urandom) >>> 6;
                l1 = int'($urandom) >>> 6;
            end else begin
                l0 = int'($urandom_range(0, 200000)) - 100000;
                l1 = int'($urandom_range(0, 200000)) - 100000;
            end
            bw = $urandom_range(0, 3);
            if (i > 0 && $urandom_range(0, 3) == 0)
                tick();
            send(i == 0, l0, l1, bw, i == nb - 1);
            model_add(l0, l1, bw);
        end
        wait_done($sformatf("rnd%0d", idx));
        check_result($sformatf("rnd%0d", idx));
        handshake($sformatf("rnd%0d", idx));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pe_valid  = 1'b0;
        pe_result = '0;
        bw_count  = '0;
        last      = 1'b0;
        acc_ready = 1'b0;
        perr_m    = 1'b0;
        model_clear();

        // reset: every output low
        repeat (3) tick();
        chk("reset_outs", 64'({in_ready, acc_valid, busy, overflow, proto_err, acc_result}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // T1: four planes of lane0=1, lane1=2 -> 255, DONE two cycles after last
        model_clear();
        for (int b = 0; b < 4; b++) begin
            send(b == 0, 1, 2, b, b == 3);
            model_add(1, 2, b);
        end
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_vld_t1", 64'(acc_valid), 64'd0);
        tick();
        chk("t1_vld_t2", 64'(acc_valid), 64'd1);
        chk("t1_const", 64'(acc_result), 64'd255);
        check_result("t1");
        handshake("t1");
        chk("t1_hold", 64'(acc_result), 64'd255);

        // T2: negative lane at top plane
        model_clear();
        send(1'b1, -5, 0, 3, 1'b1);
        model_add(-5, 0, 3);
        wait_done("t2");
        chk("t2_const", 64'(acc_result), 64'h0000_0000_FFFF_FEC0);
        check_result("t2");

        // T3: stall in DONE with a stray beat
        for (int c = 0; c < 5; c++) begin
            pe_valid = (c == 2);
            tick();
            pe_valid = 1'b0;
            chk("t3_vld", 64'(acc_valid), 64'd1);
            chk("t3_res", 64'(acc_result), 64'h0000_0000_FFFF_FEC0);
            chk("t3_rdy", 64'(in_ready), 64'd0);
        end
        perr_m = 1'b1;
        chk("t3_perr", 64'(proto_err), 64'd1);

        // start together with the handshake: ACCUM entered at once, acc cleared
        start     = 1'b1;
        acc_ready = 1'b1;
        tick();
        start     = 1'b0;
        acc_ready = 1'b0;
        chk("restart_vld", 64'(acc_valid), 64'd0);
        chk("restart_clr", 64'(acc_result), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);

        // T4: overflow from max lanes at top plane (beat without start, in ACCUM)
        model_clear();
        send(1'b0, 33554431, 33554431, 3, 1'b1);
        model_add(33554431, 33554431, 3);
        wait_done("t4");
        chk("t4_ovf_model", 64'(ovf_m), 64'd1);
        check_result("t4");
        handshake("t4");

        // T5: restart mid-product discards partial sum
        model_clear();
        send(1'b1, 100, 0, 0, 1'b0);
        send(1'b0, 100, 0, 0, 1'b0);
        send(1'b0, 100, 0, 0, 1'b0);
        model_clear();
        send(1'b1, 7, 0, 1, 1'b1);
        model_add(7, 0, 1);
        wait_done("t5");
        chk("t5_const", 64'(acc_result), 64'd28);
        check_result("t5");
        handshake("t5");

        // T6: asynchronous reset mid-ACCUM
        send(1'b1, 5, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_async", 64'({in_ready, acc_valid, busy, overflow, proto_err, acc_result}), 64'd0);
        tick();
        rst_n  = 1'b1;
        perr_m = 1'b0;
        tick();
        chk("t6_idle", 64'({acc_valid, busy, proto_err, acc_result}), 64'd0);
        model_clear();
        send(1'b1, 1, 0, 0, 1'b1);
        model_add(1, 0, 0);
        wait_done("t6");
        check_result("t6");
        handshake("t6");

        // randomized products against the model
        for (int r = 0; r < 20; r++)
            run_random(r);

        // illegal plane index on a last beat: dropped but still ends product
        model_clear();
        send(1'b1, 9, 0, 5, 1'b1);
        perr_m = 1'b1;
        wait_done("badbw");
        check_result("badbw");
        handshake("badbw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
